// File: rtl/detect_pkg.sv
// Shared types and state codes for the switch-state detection path.
package detect_pkg;

    localparam logic [1:0] ST_ON   = 2'b00;
    localparam logic [1:0] ST_OFF  = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;
    localparam logic [1:0] ST_OPEN = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_RES,
        WAIT_TICK
    } sched_state_t;

endpackage

// File: rtl/result_encoder.sv
// Priority encoder for the four measurement result flags (on > off > err > open).
module result_encoder
    import detect_pkg::*;
(
    input  logic       flag_on,
    input  logic       flag_off,
    input  logic       flag_err,
    input  logic       flag_open,
    output logic       valid,
    output logic [1:0] code
);

    always_comb begin
        valid = flag_on | flag_off | flag_err | flag_open;
        code  = ST_OPEN;
        if (flag_on)
            code = ST_ON;
        else if (flag_off)
            code = ST_OFF;
        else if (flag_err)
            code = ST_ERR;
    end

endmodule

// File: rtl/detect_scheduler.sv
// Periodic measurement scheduler with result timeout and N-in-a-row confirmation filter.
//   state     | meaning
//   IDLE      | disabled, waiting for enable
//   START     | meas_start strobe, timeout counter loaded
//   WAIT_RES  | waiting for a result flag or timeout
//   WAIT_TICK | result handled, waiting for next period tick
module detect_scheduler
    import detect_pkg::*;
#(
    parameter int PERIOD_CYC  = 50000,
    parameter int TIMEOUT_CYC = 5000,
    parameter int CONFIRM_N   = 3
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       enable,
    output logic       meas_start,
    input  logic       result_on,
    input  logic       result_off,
    input  logic       result_err,
    input  logic       result_open,
    output logic [1:0] state,
    output logic       state_valid,
    output logic       state_change,
    output logic       timeout,
    output logic [7:0] miss_cnt
);

    localparam int PW = $clog2(PERIOD_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PERIOD_LOAD  = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    MATCH_FULL   = 4'(CONFIRM_N);

    sched_state_t  fsm, fsm_nxt;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    cand;
    logic [3:0]    match_cnt;
    logic          res_valid;
    logic [1:0]    res_code;
    logic          tick, tmo_hit, publish;

    result_encoder u_enc (
        .flag_on   (result_on),
        .flag_off  (result_off),
        .flag_err  (result_err),
        .flag_open (result_open),
        .valid     (res_valid),
        .code      (res_code)
    );

    assign tick    = (period_cnt == '0);
    assign tmo_hit = (tmo_cnt == '0);
    assign publish = (match_cnt == MATCH_FULL) && (!state_valid || cand != state);

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n)
            fsm <= IDLE;
        else
            fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        if (!enable) begin
            fsm_nxt = IDLE;
        end else begin
            case (fsm)
                IDLE:      fsm_nxt = START;
                START:     fsm_nxt = WAIT_RES;
                WAIT_RES:  if (res_valid || tmo_hit) fsm_nxt = WAIT_TICK;
                WAIT_TICK: if (tick) fsm_nxt = START;
                default:   fsm_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            meas_start   <= 1'b0;
            period_cnt   <= '0;
            tmo_cnt      <= '0;
            cand         <= ST_ON;
            match_cnt    <= '0;
            state        <= ST_ON;
            state_valid  <= 1'b0;
            state_change <= 1'b0;
            timeout      <= 1'b0;
            miss_cnt     <= '0;
        end else begin
            meas_start   <= (fsm_nxt == START);
            state_change <= 1'b0;
            timeout      <= 1'b0;

            // Loaded in IDLE so the first period starts at the IDLE->START edge
            if (fsm == IDLE)
                period_cnt <= PERIOD_LOAD;
            else if (enable)
                period_cnt <= tick ? PERIOD_LOAD : period_cnt - 1'b1;

            if (fsm == START)
                tmo_cnt <= TIMEOUT_LOAD;
            else if (fsm == WAIT_RES && !tmo_hit)
                tmo_cnt <= tmo_cnt - 1'b1;

            // A flag on the last wait cycle takes precedence over the timeout
            if (!enable) begin
                match_cnt <= '0;
            end else if (fsm == WAIT_RES) begin
                if (res_valid) begin
                    if (match_cnt != '0 && res_code == cand) begin
                        if (match_cnt != MATCH_FULL)
                            match_cnt <= match_cnt + 1'b1;
                    end else begin
                        cand      <= res_code;
                        match_cnt <= 4'd1;
                    end
                end else if (tmo_hit) begin
                    timeout   <= 1'b1;
                    match_cnt <= '0;
                    if (miss_cnt != 8'hFF)
                        miss_cnt <= miss_cnt + 1'b1;
                end
            end

            if (publish) begin
                state        <= cand;
                state_valid  <= 1'b1;
                state_change <= 1'b1;
            end
        end
    end

    a_no_tick_in_wait: assert property (@(posedge clk_50MHz) disable iff (!rst_n)
        (fsm == WAIT_RES) |-> !tick);

endmodule
